// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: op select codes, handshake states, default width.
package alu_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] OP_NOT_A = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_NOT_B = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Request/result bundle between the requester, the operand stage and the 8:1 result selector.
interface alu_operand_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  localparam int OUT_W = 2 * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_sel;
  logic [OUT_W-1:0]  lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7;
  logic              mul_busy;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_sel, mul_busy,
    input  lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_sel, mul_busy,
    output lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// ALU_MUL_EARLY_EXIT_EN: stop as soon as the remaining multiplier bits are all zero.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);
  localparam int OUT_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic [OUT_W-1:0]  mcand_q, mcand_d, prod_q, prod_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d, last;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    last     = 1'b0;
    if (start_i) begin
      mcand_d  = {{DATA_W{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      last     = (cnt_q == CNT_W'(DATA_W - 1)) || (EARLY_EXIT && (mplier_d == '0));
      busy_d   = !last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done is combinational so the caller can capture the final product on the last iteration edge.
  assign done_o    = last;
  assign product_o = prod_d;
  assign busy_o    = busy_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Execute stage feeding the 8:1 ALU selector: handshake FSM, single-cycle lanes, sequential multiply.
// ALU_MUL_EARLY_EXIT_EN (in alu_seq_mul) shortens multiply latency only; results are unchanged.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus
);
  localparam int OUT_W = 2 * DATA_W;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  lanes_q [8];
  logic [OUT_W-1:0]  lanes_d [8];
  logic [2:0]        sel_q, sel_d;
  logic              in_ready, accept, mul_start, mul_done, mul_busy;
  logic [OUT_W-1:0]  mul_product;
  logic [DATA_W:0]   sum_w, diff_w;

  assign accept    = bus.in_valid && in_ready;
  assign mul_start = accept && (bus.in_sel == OP_MUL);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = (bus.in_sel == OP_MUL) ? ST_MUL : ST_HOLD;
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          in_ready = 1'b1;
          if (bus.in_valid) state_d = (bus.in_sel == OP_MUL) ? ST_MUL : ST_HOLD;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sum_w  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign diff_w = {1'b0, bus.in_a} - {1'b0, bus.in_b};

  always_comb begin
    lanes_d = lanes_q;
    sel_d   = sel_q;
    if (accept) begin
      lanes_d[0] = {{DATA_W{1'b0}}, ~bus.in_a};
      lanes_d[1] = {{DATA_W{1'b0}}, bus.in_a | bus.in_b};
      lanes_d[2] = {{DATA_W{1'b0}}, bus.in_a & bus.in_b};
      lanes_d[3] = {{DATA_W{1'b0}}, bus.in_a ^ bus.in_b};
      lanes_d[4] = {{(DATA_W-1){1'b0}}, sum_w};
      lanes_d[5] = {{(DATA_W-1){1'b0}}, diff_w};
      lanes_d[6] = '0;
      lanes_d[7] = {{DATA_W{1'b0}}, ~bus.in_b};
      sel_d      = bus.in_sel;
    end else if ((state_q == ST_MUL) && mul_done) begin
      lanes_d[6] = mul_product;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lanes_q[gi] <= '0;
      else        lanes_q[gi] <= lanes_d[gi];
    end
  end

  alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (bus.in_a),
    .b_i       (bus.in_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sel   = sel_q;
  assign bus.mul_busy  = mul_busy;
  assign bus.lane0     = lanes_q[0];
  assign bus.lane1     = lanes_q[1];
  assign bus.lane2     = lanes_q[2];
  assign bus.lane3     = lanes_q[3];
  assign bus.lane4     = lanes_q[4];
  assign bus.lane5     = lanes_q[5];
  assign bus.lane6     = lanes_q[6];
  assign bus.lane7     = lanes_q[7];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against an arithmetic reference model.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int OW = 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_W(DW)) bus ();

  alu_operand_stage #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [OW-1:0] obs [8];
  assign obs[0] = bus.lane0;
  assign obs[1] = bus.lane1;
  assign obs[2] = bus.lane2;
  assign obs[3] = bus.lane3;
  assign obs[4] = bus.lane4;
  assign obs[5] = bus.lane5;
  assign obs[6] = bus.lane6;
  assign obs[7] = bus.lane7;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int MASK = (1 << DW) - 1;

  function automatic logic [OW-1:0] ref_lane(input int idx, input int a, input int b, input int sel);
    int r;
    case (idx)
      0: r = MASK - a;
      1: r = a | b;
      2: r = a & b;
      3: r = a ^ b;
      4: r = a + b;
      5: r = (a - b + (2 << DW)) % (2 << DW);
      6: r = (sel == 6) ? a * b : 0;
      default: r = MASK - b;
    endcase
    return OW'(r);
  endfunction

  // Number of shift-add iterations: the bit length of B when early exit is on (at least one).
  function automatic int ref_iters(input int b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int n = 1;
    while ((b >> n) != 0) n++;
    return n;
`else
    return DW;
`endif
  endfunction

  task automatic check_lanes(input string tag, input int a, input int b, input int sel);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("%s_lane%0d", tag, i), 32'(obs[i]), 32'(ref_lane(i, a, b, sel)));
    check_val({tag, "_out_sel"}, 32'(bus.out_sel), 32'(sel));
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    #1;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one request, measure latency, apply `stall` cycles of backpressure, then consume.
  task automatic run_txn(input string tag, input int a, input int b, input int sel, input int stall);
    int lat = 0;
    int busy = 0;
    int rdy_bad = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = DW'(a);
    bus.in_b      = DW'(b);
    bus.in_sel    = 3'(sel);
    bus.out_ready = 1'b0;
    wait_ready(tag);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mul_busy) busy++;
      if (!bus.out_valid && bus.in_ready) rdy_bad++;
    end while (!bus.out_valid && lat < 60);
    check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'((sel == 6) ? ref_iters(b) + 1 : 1));
    if (sel == 6) begin
      check_val({tag, "_busy_cycles"}, 32'(busy), 32'(ref_iters(b)));
      check_val({tag, "_ready_during_mul"}, 32'(rdy_bad), 32'd0);
    end
    check_lanes(tag, a, b, sel);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      check_val({tag, "_stall_ready"}, 32'(bus.in_ready), 32'd0);
      check_val({tag, "_stall_lane"}, 32'(obs[sel]), 32'(ref_lane(sel, a, b, sel)));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    $display("txn %s a=%02h b=%02h sel=%0d latency=%0d stall=%0d", tag, a, b, sel, lat, stall);
  endtask

  initial begin
    int a1, b1, a2, b2, lat;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;

    #12;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_mul_busy", 32'(bus.mul_busy), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_out_sel", 32'(bus.out_sel), 32'd0);
    for (int i = 0; i < 8; i++) check_val($sformatf("rst_lane%0d", i), 32'(obs[i]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("logic", 'hF0, 'h0F, 1, 0);
    run_txn("carry", 'hFF, 'h01, 4, 0);
    run_txn("borrow", 'h05, 'h0A, 5, 1);
    run_txn("mul_ff", 'hFF, 'hFF, 6, 0);
    run_txn("early", 'h03, 'h02, 6, 0);
    run_txn("mul_b0", 'h5A, 'h00, 6, 0);

    // Backpressure for 5 cycles with the next request already pending, then same-cycle reissue.
    a1 = 'h3C; b1 = 'hA5; a2 = 'h81; b2 = 'h7E;
    bus.in_valid = 1'b1; bus.in_a = DW'(a1); bus.in_b = DW'(b1); bus.in_sel = OP_AND;
    bus.out_ready = 1'b0;
    wait_ready("b2b_first");
    @(posedge clk);
    #1 begin bus.in_a = DW'(a2); bus.in_b = DW'(b2); bus.in_sel = OP_XOR; end
    @(negedge clk);
    check_val("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    check_lanes("b2b_first", a1, b1, 2);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_val("b2b_hold_ready", 32'(bus.in_ready), 32'd0);
      check_val("b2b_hold_lane2", 32'(obs[2]), 32'(ref_lane(2, a1, b1, 2)));
      check_val("b2b_hold_sel", 32'(bus.out_sel), 32'd2);
    end
    bus.out_ready = 1'b1;
    #1 check_val("b2b_reissue_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.out_ready = 1'b0; end
    @(negedge clk);
    check_val("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    check_lanes("b2b_second", a2, b2, 3);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_val("b2b_drained", 32'(bus.out_valid), 32'd0);
    $display("txn b2b a=%02h b=%02h then a=%02h b=%02h", a1, b1, a2, b2);

    // Asynchronous reset in the middle of a multiply.
    bus.in_valid = 1'b1; bus.in_a = 8'h03; bus.in_b = 8'h07; bus.in_sel = OP_MUL;
    wait_ready("rstmul");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rstmul_busy_before", 32'(bus.mul_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstmul_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rstmul_mul_busy", 32'(bus.mul_busy), 32'd0);
    check_val("rstmul_out_sel", 32'(bus.out_sel), 32'd0);
    for (int i = 0; i < 8; i++) check_val($sformatf("rstmul_lane%0d", i), 32'(obs[i]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn rstmul a=03 b=07 reset after 4 cycles");
    run_txn("after_rst", 'h03, 'h07, 6, 0);

    for (int t = 0; t < 40; t++) begin
      run_txn($sformatf("rnd%0d", t), int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)),
              int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
    end

    lat = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Upstream execute stage for the 8:1 ALU result selector.
- Accepts one operand pair (A, B) and a 3-bit op select per transaction through a valid/ready handshake.
- Computes the eight operation lanes (NOT A, OR, AND, XOR, add, sub, multiply, NOT B) as 16-bit registered results, plus the registered select.
- Multiply runs on a sequential shift-add engine; every other op completes in one cycle. The downstream selector consumes the lanes and select while out_valid is high.

Parameters:
- DATA_W, 8, operand width; lane width is fixed at OUT_W = 2*DATA_W (16 by default).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  stage can accept a request this cycle
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_sel  input  3  op select (000 NOT A, 001 OR, 010 AND, 011 XOR, 100 ADD, 101 SUB, 110 MUL, 111 NOT B)
- out_valid  output  1  lanes and out_sel valid
- out_ready  input  1  downstream consumes this cycle
- out_sel  output  3  registered select for the downstream selector
- lane0..lane7  output  OUT_W each  op results, index equals select code
- mul_busy  output  1  shift-add engine active

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, mul_busy=0, out_sel=0, all lanes=0. Takes effect immediately, including mid-multiply; the partial product is discarded.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, mul_busy=1.
  - HOLD: out_valid=1.
- Accept: occurs when in_valid & in_ready. in_ready = (state==IDLE) | (state==HOLD & out_ready), so back-to-back issue is possible.
- On accept, the lanes are registered and zero-extended to OUT_W:
  - lane0 = ~A
  - lane1 = A|B
  - lane2 = A&B
  - lane3 = A^B
  - lane4 = A+B (DATA_W+1 bits, carry in bit DATA_W)
  - lane5 = A-B mod 2^(DATA_W+1) (bit DATA_W = borrow)
  - lane7 = ~B
  - lane6 = 0; out_sel = in_sel.
- Non-MUL op: next state HOLD; out_valid is asserted the cycle after accept (latency 1).
- MUL op: next state MUL.
  - Multiplicand register = A, multiplier register = B, product = 0, counter = 0.
  - Each cycle: if the multiplier LSB is 1, product += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - After DATA_W iterations, lane6 = product and the state moves to HOLD; out_valid first rises at cycle DATA_W+1 after accept.
- HOLD:
  - Lanes and out_sel stay stable while out_ready=0.
  - On out_ready=1: if a new accept occurs in the same cycle, behave as the accept from IDLE; otherwise go to IDLE and deassert out_valid.
- in_valid while in MUL or non-ready HOLD is ignored (not accepted). The requester must hold its request.
- Product width is exactly OUT_W; no overflow is possible for unsigned DATA_W×DATA_W.

Optional Feature:
- ALU_MUL_EARLY_EXIT_EN
  - Defined: MUL goes to HOLD after the iteration that leaves the remaining multiplier register zero, or at DATA_W iterations, whichever comes first. B=0 takes exactly 1 iteration, so out_valid rises 2 cycles after accept.
  - Undefined: fixed DATA_W iterations. Results are identical either way; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - op select localparams (OP_NOT_A … OP_NOT_B)
  - state enum type (IDLE, MUL, HOLD)
  - DATA_W default
- One sub-module, alu_seq_mul: start/done handshake, shift-add engine, counter, early-exit logic.
- alu_operand_stage holds the handshake FSM and the single-cycle lanes.

Test Plan:
- Logic/arith lanes: A=8'hF0, B=8'h0F, sel=001, out_ready=1 → out_valid next cycle; lane0..7 = 000F, 00FF, 0000, 00FF, 00FF, 00E1, 0000, 00F0; out_sel=001.
- Carry/borrow:
  - A=FF, B=01, sel=100 → lane4=0100.
  - A=05, B=0A, sel=101 → lane5=01FB.
- Multiply: A=FF, B=FF, sel=110 → mul_busy for 8 cycles, out_valid at cycle 9, lane6=FE01, in_ready low throughout.
- Backpressure + back-to-back:
  - Hold out_ready=0 for 5 cycles in HOLD → lanes stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 → new request accepted that same cycle, next result valid the following cycle.
- Reset mid-multiply: A=03, B=07, MUL, drop rst_n at cycle 4 → immediately out_valid=0, mul_busy=0, lanes=0. After release, A=03, B=07 → lane6=0015.
- Early exit: A=03, B=02, sel=110 → with ALU_MUL_EARLY_EXIT_EN, out_valid at cycle 3; without it, cycle 9; lane6=0006 in both cases.
